sdiv_mag: RTL and testbench
===========================

Name: sdiv_mag

Overview:
- Iterative signed fixed-point divider, front half: computes |a| / |b| in fixed point and separately reports the result sign.
- Sits directly upstream of the conditional-negate stage: `f` feeds its argument and `neg` feeds its `cond`, which restores the signed quotient one cycle later.
- Shares the `fixedp` bundle (`g.clk`, `g.reset`, `g.WIDTH`, `g.FRAC`) with the rest of the matrix datapath.

Parameters:
- `g.WIDTH`, from `fixedp`: total fixed-point word width W, two's complement.
- `g.FRAC`, from `fixedp`: fraction bits F. N = W+F is the number of iteration cycles.

Ports:
- `g.clk`  input  1  clock, rising edge; all state is on this clock.
- `g.reset`  input  1  synchronous, active-high reset.
- `a`  input  W  dividend, signed fixed point.
- `b`  input  W  divisor, signed fixed point.
- `req`  input  1  start request; sampled only when `busy`=0.
- `busy`  output  1  division in progress.
- `valid`  output  1  one-cycle pulse: `f`/`neg`/`dbz` are new.
- `f`  output  W  unsigned quotient magnitude, saturated.
- `neg`  output  1  quotient sign (1 = negative); drives the negate stage's `cond`.
- `dbz`  output  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (sync, when `g.reset`=1 at an edge):
  - State goes to IDLE; `busy`, `valid`, `f`, `neg`, `dbz` all go to 0.
  - This applies mid-operation too: the division in flight is discarded and no `valid` follows.
- States:
  - IDLE: `busy`=0. If `req`=1 at edge k, capture operands and go to ITER; `busy`=1 from k.
  - ITER: one quotient bit per cycle for N cycles, MSB first.
  - DONE: one cycle. Saturate, register outputs, pulse `valid`, then return to IDLE.
- Capture at edge k:
  - `ma` = |a| and `mb` = |b|, both W-bit unsigned. The most-negative input has magnitude 2^(W-1), which fits.
  - `neg_r` = sign(a) XOR sign(b).
  - `dbz_r` = (b == 0).
  - Numerator = `ma` << F, width N.
- Iteration: restoring division. Remainder register W+1 bits; each cycle shift in the next numerator bit, trial subtract `mb`, keep the result if non-negative, and shift the quotient bit into an N-bit quotient register.
- Latency: `req` at edge k gives `valid`=1 during the cycle after edge k+N+1. `busy` falls at that same edge. Fixed latency for every operand set, including divide-by-zero.
- Saturation limit L:
  - L = 2^(W-1) when `neg_r`=1; L = 2^(W-1)-1 otherwise.
  - `f` = min(quotient, L), truncated toward zero. The remainder is discarded; no rounding.
- Divide by zero: `f` = L, `neg` = sign(a), `dbz`=1.
- 0 / nonzero: `f`=0 and `neg`=0. The sign is forced positive so the downstream stage never produces a "negative zero" path.
- Output hold: `f`, `neg`, `dbz` hold their values until the next DONE; the downstream negate stage may sample them late. `valid` is high for exactly one cycle.
- `req` while `busy`=1 is ignored; no queueing.
- `req` held high in IDLE starts back-to-back divisions: the new capture happens on the edge after `valid`, so throughput is one result per N+2 cycles.

Decomposition:
- Shared package `fixedp_pkg`:
  - State enum `sdiv_state_t` {IDLE, ITER, DONE}.
  - Helper function `fx_abs(W-bit) -> W-bit unsigned`, reused by other signed stages.
- Sub-module `udiv_step`: purely combinational; one restoring step (remainder in, next bit, `mb` -> remainder out, quotient bit).
- The top level owns the FSM, counter (ceil(log2(N+1)) bits), capture and saturation.

Test Plan (W=16, F=8, N=24):
- `a`=0x0180 (1.5), `b`=0x0080 (0.5), `req` 1 cycle -> `valid` 25 cycles later; `f`=0x0300, `neg`=0, `dbz`=0; `busy` high throughout.
- `a`=0xFE80 (-1.5), `b`=0x0080 -> `f`=0x0300, `neg`=1; the negate stage then outputs 0xFD00.
- `a`=0x8000 (-128.0), `b`=0x0100 (1.0) -> `f`=0x8000, `neg`=1, not clipped. `a`=0x7FFF, `b`=0x0001 -> `f`=0x7FFF, `neg`=0. `a`=0x7FFF, `b`=0xFFFF -> `f`=0x8000, `neg`=1.
- `a`=0x0100, `b`=0x0000 -> `f`=0x7FFF, `neg`=0, `dbz`=1, same 25-cycle latency. `a`=0xFF00, `b`=0 -> `f`=0x8000, `neg`=1, `dbz`=1.
- Second `req` at cycle 5 of a run -> ignored, exactly one `valid`. `req` held high -> `valid` pulses every 26 cycles with correct results.
- `g.reset` asserted at cycle 10 of a run -> next edge `busy`=0, `f`=0, `neg`=0, `dbz`=0; no `valid` for the aborted operation; the next `req` completes normally.

Source files
------------

// File: rtl/fixedp_pkg.sv
// Shared fixed-point definitions for the matrix datapath: word format,
// divider state encoding and the signed-magnitude helper.
package fixedp_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int NITER = WIDTH + FRAC;
    localparam int CNT_W = $clog2(NITER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } sdiv_state_t;

    // Magnitude of a two's-complement word; the most-negative value maps to 2^(W-1).
    function automatic logic [WIDTH-1:0] fx_abs(input logic [WIDTH-1:0] x);
        fx_abs = x[WIDTH-1] ? ((~x) + WIDTH'(1'b1)) : x;
    endfunction

endpackage

// File: rtl/sdiv_mag_if.sv
// Operand/result bundle between a requester and the magnitude divider.
interface sdiv_mag_if;
    import fixedp_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             req;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] f;
    logic             neg;
    logic             dbz;

    modport master (output a, b, req, input busy, valid, f, neg, dbz);
    modport slave  (input a, b, req, output busy, valid, f, neg, dbz);

endinterface

// File: rtl/udiv_step.sv
// One combinational restoring-division step: shift in a numerator bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module udiv_step #(
    parameter int W = 16
) (
    input  logic [W:0]   rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] mb,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] shifted_s;

    assign shifted_s = {rem_in, bit_in};
    assign q_bit     = (shifted_s >= {2'b00, mb});
    assign rem_out   = q_bit ? (W+1)'(shifted_s - {2'b00, mb}) : (W+1)'(shifted_s);

endmodule

// File: rtl/sdiv_mag.sv
// Iterative signed fixed-point divider front half: produces the saturated
// quotient magnitude |a|/|b| and its sign for the downstream negate stage.
module sdiv_mag
    import fixedp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    sdiv_mag_if.slave bus
);

    sdiv_state_t        state_r;
    sdiv_state_t        state_next;
    logic [NITER-1:0]   num_r;
    logic [WIDTH:0]     rem_r;
    logic [NITER-1:0]   q_r;
    logic [WIDTH-1:0]   mb_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               neg_r;
    logic               dbz_r;
    logic               zero_r;
    logic               busy_r;
    logic               valid_r;
    logic [WIDTH-1:0]   f_r;
    logic               fneg_r;
    logic               fdbz_r;
    logic [WIDTH:0]     step_rem_s;
    logic               step_q_s;
    logic [WIDTH-1:0]   lim_s;
    logic [WIDTH-1:0]   f_s;
    logic               neg_s;

    udiv_step #(.W(WIDTH)) u_step (
        .rem_in  (rem_r),
        .bit_in  (num_r[NITER-1]),
        .mb      (mb_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req) state_next = ITER;
                else         state_next = IDLE;
            end
            ITER: begin
                if (cnt_r == CNT_W'(NITER - 1)) state_next = DONE;
                else                            state_next = ITER;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Saturation; a negative result may reach 2^(W-1), a positive one only 2^(W-1)-1.
    always_comb begin
        lim_s = neg_r ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        f_s   = {WIDTH{1'b0}};
        neg_s = neg_r;
        if (dbz_r) begin
            f_s   = lim_s;
        end else if (zero_r) begin
            neg_s = 1'b0;
        end else if (q_r > NITER'(lim_s)) begin
            f_s   = lim_s;
        end else begin
            f_s   = q_r[WIDTH-1:0];
        end
    end

    // Operand capture, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_r   <= {NITER{1'b0}};
            rem_r   <= {(WIDTH+1){1'b0}};
            q_r     <= {NITER{1'b0}};
            mb_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_r   <= 1'b0;
            dbz_r   <= 1'b0;
            zero_r  <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            f_r     <= {WIDTH{1'b0}};
            fneg_r  <= 1'b0;
            fdbz_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            busy_r  <= (state_next != IDLE);
            case (state_r)
                IDLE: begin
                    if (bus.req) begin
                        num_r  <= {fx_abs(bus.a), {FRAC{1'b0}}};
                        mb_r   <= fx_abs(bus.b);
                        neg_r  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        dbz_r  <= (bus.b == {WIDTH{1'b0}});
                        zero_r <= (bus.a == {WIDTH{1'b0}});
                        rem_r  <= {(WIDTH+1){1'b0}};
                        q_r    <= {NITER{1'b0}};
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ITER: begin
                    num_r <= {num_r[NITER-2:0], 1'b0};
                    rem_r <= step_rem_s;
                    q_r   <= {q_r[NITER-2:0], step_q_s};
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                end
                DONE: begin
                    f_r     <= f_s;
                    fneg_r  <= neg_s;
                    fdbz_r  <= dbz_r;
                    valid_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.valid = valid_r;
    assign bus.f     = f_r;
    assign bus.neg   = fneg_r;
    assign bus.dbz   = fdbz_r;

endmodule

// File: tb/tb_sdiv_mag.sv
// Scoreboard bench for sdiv_mag: expected results are queued at request time
// and compared, including arrival cycle, whenever valid pulses.
module tb_sdiv_mag;

    localparam int LAT = 25;

    typedef struct {
        logic [15:0] f;
        logic        neg;
        logic        dbz;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    sdiv_mag_if bus();

    sdiv_mag dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [15:0] ma;
        logic [15:0] mb;
        logic [15:0] lim;
        logic [31:0] q;
        ma    = a[15] ? 16'(16'd0 - a) : a;
        mb    = b[15] ? 16'(16'd0 - b) : b;
        e.neg = a[15] ^ b[15];
        e.dbz = 1'b0;
        e.due = 0;
        lim   = e.neg ? 16'h8000 : 16'h7FFF;
        if (b == 16'h0000) begin
            e.f   = lim;
            e.neg = a[15];
            e.dbz = 1'b1;
        end else if (a == 16'h0000) begin
            e.f   = 16'h0000;
            e.neg = 1'b0;
        end else begin
            q   = (32'(ma) * 32'd256) / 32'(mb);
            e.f = (q > 32'(lim)) ? lim : q[15:0];
        end
        return e;
    endfunction

    // Result monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(bus.valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("f",         32'(bus.f),   32'(e.f));
                check("neg",       32'(bus.neg), 32'(e.neg));
                check("dbz",       32'(bus.dbz), 32'(e.dbz));
                check("valid_cyc", 32'(cyc),     32'(e.due));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input bit extra);
        exp_t e;
        bit   seen;
        wait_idle();
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        e     = model(a, b);
        e.due = cyc + LAT;
        sb.push_back(e);
        bus.req = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < LAT + 10 && !seen; i++) begin
            @(negedge clk);
            if (extra && i == 4) begin
                bus.a   = 16'h1234;
                bus.b   = 16'h0011;
                bus.req = 1'b1;
            end else begin
                bus.req = 1'b0;
            end
            if (bus.valid === 1'b1) seen = 1'b1;
            else                    check("busy_run", 32'(bus.busy), 32'd1);
        end
        if (!seen) begin
            check("valid_timeout", 32'd0, 32'd1);
        end else begin
            check("busy_fall", 32'(bus.busy), 32'd0);
            repeat (3) @(negedge clk);
            check("f_hold",   32'(bus.f),     32'(e.f));
            check("neg_hold", 32'(bus.neg),   32'(e.neg));
            check("valid_1c", 32'(bus.valid), 32'd0);
        end
        if (extra) begin
            repeat (30) @(negedge clk);
            check("sb_empty", 32'(sb.size()), 32'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        logic [15:0] ra;
        logic [15:0] rb;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        bus.a   = 16'h0000;
        bus.b   = 16'h0000;
        bus.req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_f",     32'(bus.f),     32'd0);
        check("rst_neg",   32'(bus.neg),   32'd0);
        check("rst_dbz",   32'(bus.dbz),   32'd0);
        reset = 1'b0;

        run_one(16'h0180, 16'h0080, 1'b0);
        run_one(16'hFE80, 16'h0080, 1'b0);
        run_one(16'h8000, 16'h0100, 1'b0);
        run_one(16'h7FFF, 16'h0001, 1'b0);
        run_one(16'h7FFF, 16'hFFFF, 1'b0);
        run_one(16'h0100, 16'h0000, 1'b0);
        run_one(16'hFF00, 16'h0000, 1'b0);
        run_one(16'h0000, 16'h0100, 1'b0);
        run_one(16'h8000, 16'h8000, 1'b0);
        run_one(16'h0300, 16'hFF80, 1'b1);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 255));
            if (i[0]) rb = 16'(16'd0 - rb);
            run_one(ra, rb, 1'b0);
        end

        // req held high: captures every N+2 cycles, operands changed after each capture
        wait_idle();
        @(negedge clk);
        bus.a   = 16'h0180;
        bus.b   = 16'h0080;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        e     = model(16'h0180, 16'h0080);
        e.due = cyc + LAT;
        sb.push_back(e);
        bus.a = 16'hC000;
        bus.b = 16'h0300;
        repeat (26) @(posedge clk);
        #1;
        e     = model(16'hC000, 16'h0300);
        e.due = cyc + LAT;
        sb.push_back(e);
        bus.a = 16'h7000;
        bus.b = 16'h0010;
        repeat (26) @(posedge clk);
        #1;
        e     = model(16'h7000, 16'h0010);
        e.due = cyc + LAT;
        sb.push_back(e);
        bus.req = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", 32'(sb.size()), 32'd0);

        // reset mid-operation discards the division in flight
        wait_idle();
        @(negedge clk);
        bus.a   = 16'h0200;
        bus.b   = 16'h0080;
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_f",    32'(bus.f),    32'd0);
        check("mid_rst_neg",  32'(bus.neg),  32'd0);
        check("mid_rst_dbz",  32'(bus.dbz),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (35) @(negedge clk);
        check("abort_no_valid", 32'(sb.size()), 32'd0);
        run_one(16'hFE80, 16'h0080, 1'b0);

        repeat (5) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
